imem_fetch_ctrl: RTL and testbench

IMEM_FETCH_CTRL -- requirements
Module: imem_fetch_ctrl

---
 rtl/fetch_ctrl_pkg.sv | 15 +
 rtl/sat_counter.sv | 19 +
 rtl/imem_fetch_ctrl.sv | 149 ++++++++++++++
 tb/tb_imem_fetch_ctrl.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/fetch_ctrl_pkg.sv
// rtl/fetch_ctrl_pkg.sv - shared types and constants for the instruction fetch controller
package fetch_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        WAIT  = 3'd2,
        HOLD  = 3'd3,
        DRAIN = 3'd4
    } fetch_state_t;

    // addi x0,x0,0 is the bubble the IF/ID register sees when nothing was fetched
    localparam logic [31:0] NOP_INSN = 32'h0000_0013;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with enable and synchronous clear
module sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             en,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk) begin
        if (clr) begin
            count <= '0;
        end else if (en && (count != {WIDTH{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/imem_fetch_ctrl.sv
// rtl/imem_fetch_ctrl.sv - single-outstanding instruction fetch controller with stall/redirect handling
module imem_fetch_ctrl #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] NOP_INSN   = fetch_ctrl_pkg::NOP_INSN
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] pc_f,
    input  logic                  pcsrc_e,
    input  logic                  hazard_stall,
    output logic                  imem_req,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic                  imem_ack,
    input  logic [DATA_WIDTH-1:0] imem_rdata,
    output logic [DATA_WIDTH-1:0] ins_f,
    output logic                  ins_valid,
    output logic                  pc_write,
    output logic                  if_id_write,
    output logic [31:0]           stall_cnt,
    output logic                  proto_err
);

    import fetch_ctrl_pkg::*;

    fetch_state_t          state;
    fetch_state_t          next_state;
    logic [DATA_WIDTH-1:0] hold_buf;
    logic                  capture;
    logic                  discard;
    logic                  cnt_en;
    logic                  stray_ack;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            hold_buf  <= NOP_INSN;
            proto_err <= 1'b0;
        end else begin
            state <= next_state;
            if (capture) begin
                hold_buf <= imem_rdata;
            end else if (discard) begin
                hold_buf <= NOP_INSN;
            end
            if (stray_ack) begin
                proto_err <= 1'b1;
            end
        end
    end

    always_comb begin
        next_state  = state;
        imem_req    = 1'b0;
        imem_addr   = '0;
        ins_f       = NOP_INSN;
        ins_valid   = 1'b0;
        pc_write    = 1'b0;
        if_id_write = 1'b0;
        capture     = 1'b0;
        discard     = 1'b0;
        cnt_en      = 1'b0;
        stray_ack   = 1'b0;

        case (state)
            IDLE: begin
                stray_ack  = imem_ack;
                next_state = ISSUE;
            end
            ISSUE: begin
                imem_req   = 1'b1;
                imem_addr  = pc_f;
                stray_ack  = imem_ack;
                next_state = pcsrc_e ? DRAIN : WAIT;
            end
            WAIT: begin
                if (imem_ack) begin
                    if (pcsrc_e) begin
                        next_state = ISSUE;
                    end else begin
                        ins_f     = imem_rdata;
                        ins_valid = 1'b1;
                        if (!hazard_stall) begin
                            pc_write   = 1'b1;
                            next_state = ISSUE;
                        end else begin
                            capture    = 1'b1;
                            next_state = HOLD;
                        end
                    end
                end else begin
                    cnt_en = 1'b1;
                    if (pcsrc_e) begin
                        next_state = DRAIN;
                    end
                end
            end
            HOLD: begin
                ins_f     = hold_buf;
                ins_valid = 1'b1;
                stray_ack = imem_ack;
                if (pcsrc_e) begin
                    discard    = 1'b1;
                    next_state = ISSUE;
                end else if (!hazard_stall) begin
                    pc_write   = 1'b1;
                    next_state = ISSUE;
                end
            end
            DRAIN: begin
                // The response to the abandoned request must be swallowed before reissuing
                if (imem_ack) begin
                    next_state = ISSUE;
                end else begin
                    cnt_en = 1'b1;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase

        if (state != IDLE) begin
            if_id_write = !hazard_stall || pcsrc_e;
            if (pcsrc_e) begin
                pc_write = 1'b1;
            end
        end

        if (rst) begin
            imem_req    = 1'b0;
            imem_addr   = '0;
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            ins_valid   = 1'b0;
            ins_f       = NOP_INSN;
        end
    end

    sat_counter #(
        .WIDTH(32)
    ) u_stall_cnt (
        .clk   (clk),
        .clr   (rst),
        .en    (cnt_en),
        .count (stall_cnt)
    );

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// tb/tb_imem_fetch_ctrl.sv - directed self-checking bench for imem_fetch_ctrl
module tb_imem_fetch_ctrl;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        rst;
    logic [31:0] pc_f;
    logic        pcsrc_e;
    logic        hazard_stall;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] ins_f;
    logic        ins_valid;
    logic        pc_write;
    logic        if_id_write;
    logic [31:0] stall_cnt;
    logic        proto_err;

    int checks = 0;
    int errors = 0;

    imem_fetch_ctrl #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32),
        .NOP_INSN   (32'h0000_0013)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .pc_f         (pc_f),
        .pcsrc_e      (pcsrc_e),
        .hazard_stall (hazard_stall),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ack     (imem_ack),
        .imem_rdata   (imem_rdata),
        .ins_f        (ins_f),
        .ins_valid    (ins_valid),
        .pc_write     (pc_write),
        .if_id_write  (if_id_write),
        .stall_cnt    (stall_cnt),
        .proto_err    (proto_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive one cycle's inputs at the falling edge, then let combinational outputs settle
    task automatic cyc(input logic r, input logic ack, input logic [31:0] rd,
                       input logic st, input logic ps, input logic [31:0] pc);
        @(negedge clk);
        rst          = r;
        imem_ack     = ack;
        imem_rdata   = rd;
        hazard_stall = st;
        pcsrc_e      = ps;
        pc_f         = pc;
        #1;
    endtask

    initial begin
        rst = 1'b1; imem_ack = 1'b0; imem_rdata = '0;
        hazard_stall = 1'b0; pcsrc_e = 1'b0; pc_f = '0;

        cyc(1, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0);
        check("rst_req", imem_req, 0);
        check("rst_pc_write", pc_write, 0);
        check("rst_if_id_write", if_id_write, 0);
        check("rst_ins_valid", ins_valid, 0);
        check("rst_ins_f", ins_f, NOP);
        check("rst_stall_cnt", stall_cnt, 0);
        check("rst_proto_err", proto_err, 0);

        // Basic fetch with 2-cycle memory
        cyc(0, 0, 0, 0, 0, 0);                       // cycle 0: IDLE
        check("c0_req", imem_req, 0);
        check("c0_if_id_write", if_id_write, 0);
        cyc(0, 0, 0, 0, 0, 0);                       // cycle 1: ISSUE
        check("c1_req", imem_req, 1);
        check("c1_addr", imem_addr, 32'h0);
        check("c1_if_id_write", if_id_write, 1);
        cyc(0, 0, 0, 0, 0, 0);                       // cycle 2: WAIT
        check("c2_req", imem_req, 0);
        check("c2_ins_valid", ins_valid, 0);
        check("c2_ins_f", ins_f, NOP);
        check("c2_pc_write", pc_write, 0);
        cyc(0, 1, 32'h0050_0093, 0, 0, 0);          // cycle 3: WAIT ack
        check("c3_ins_valid", ins_valid, 1);
        check("c3_ins_f", ins_f, 32'h0050_0093);
        check("c3_pc_write", pc_write, 1);
        check("c3_stall_cnt", stall_cnt, 1);
        cyc(0, 0, 0, 0, 0, 32'h4);                   // cycle 4: ISSUE
        check("c4_req", imem_req, 1);
        check("c4_addr", imem_addr, 32'h4);

        // Ack under load-use stall, two stalled cycles then release
        cyc(0, 1, 32'h0010_0113, 1, 0, 32'h4);      // cycle 5: WAIT ack, stall
        check("c5_pc_write", pc_write, 0);
        check("c5_if_id_write", if_id_write, 0);
        check("c5_ins_f", ins_f, 32'h0010_0113);
        cyc(0, 0, 32'hFFFF_FFFF, 1, 0, 32'h4);      // cycle 6: HOLD, stall
        check("c6_pc_write", pc_write, 0);
        check("c6_if_id_write", if_id_write, 0);
        check("c6_ins_f", ins_f, 32'h0010_0113);
        check("c6_ins_valid", ins_valid, 1);
        check("c6_req", imem_req, 0);
        cyc(0, 0, 0, 0, 0, 32'h4);                   // cycle 7: HOLD release
        check("c7_pc_write", pc_write, 1);
        check("c7_if_id_write", if_id_write, 1);
        check("c7_ins_f", ins_f, 32'h0010_0113);
        cyc(0, 0, 0, 0, 0, 32'h8);                   // cycle 8: ISSUE
        check("c8_req", imem_req, 1);
        check("c8_addr", imem_addr, 32'h8);

        // Redirect while waiting; late response must never reach ins_f
        cyc(0, 0, 0, 0, 1, 32'h8);                   // cycle 9: WAIT, redirect
        check("c9_pc_write", pc_write, 1);
        check("c9_if_id_write", if_id_write, 1);
        check("c9_ins_valid", ins_valid, 0);
        cyc(0, 0, 0, 0, 0, 32'h100);                 // cycle 10: DRAIN
        check("c10_req", imem_req, 0);
        check("c10_pc_write", pc_write, 0);
        cyc(0, 0, 0, 0, 1, 32'h100);                 // cycle 11: DRAIN, repeated redirect
        check("c11_req", imem_req, 0);
        check("c11_ins_valid", ins_valid, 0);
        cyc(0, 1, 32'hDEAD_BEEF, 0, 0, 32'h100);    // cycle 12: DRAIN ack
        check("c12_ins_f", ins_f, NOP);
        check("c12_ins_valid", ins_valid, 0);
        check("c12_stall_cnt", stall_cnt, 4);
        cyc(0, 0, 0, 0, 0, 32'h100);                 // cycle 13: ISSUE
        check("c13_req", imem_req, 1);
        check("c13_addr", imem_addr, 32'h100);

        // Redirect and stall together in HOLD
        cyc(0, 1, 32'h0020_8193, 1, 0, 32'h100);    // cycle 14: WAIT ack, stall
        check("c14_pc_write", pc_write, 0);
        cyc(0, 0, 0, 1, 1, 32'h100);                 // cycle 15: HOLD, stall+redirect
        check("c15_pc_write", pc_write, 1);
        check("c15_if_id_write", if_id_write, 1);
        check("c15_req", imem_req, 0);
        cyc(0, 0, 0, 0, 0, 32'h200);                 // cycle 16: ISSUE
        check("c16_req", imem_req, 1);
        check("c16_addr", imem_addr, 32'h200);
        check("c16_proto_err", proto_err, 0);

        // Saturation of the wait counter
        cyc(0, 0, 0, 0, 0, 32'h200);                 // cycle 17: WAIT
        force dut.u_stall_cnt.count = 32'hFFFF_FFFE;
        #1;
        release dut.u_stall_cnt.count;
        cyc(0, 0, 0, 0, 0, 32'h200);                 // cycle 18: WAIT
        check("c18_stall_cnt", stall_cnt, 32'hFFFF_FFFF);
        cyc(0, 0, 0, 0, 0, 32'h200);                 // cycle 19: WAIT
        check("c19_stall_cnt", stall_cnt, 32'hFFFF_FFFF);
        cyc(0, 0, 0, 0, 0, 32'h200);                 // cycle 20: WAIT
        check("c20_stall_cnt", stall_cnt, 32'hFFFF_FFFF);
        check("c20_req", imem_req, 0);

        // Reset mid-request, then a stray ack in IDLE
        cyc(1, 0, 0, 0, 0, 32'h0);
        check("rst2_req", imem_req, 0);
        check("rst2_if_id_write", if_id_write, 0);
        cyc(0, 1, 32'h1234_5678, 0, 0, 32'h0);      // IDLE with stray ack
        check("r0_stall_cnt", stall_cnt, 0);
        check("r0_proto_err", proto_err, 0);
        check("r0_ins_valid", ins_valid, 0);
        cyc(0, 0, 0, 0, 0, 32'h40);                  // ISSUE
        check("r1_proto_err", proto_err, 1);
        check("r1_req", imem_req, 1);
        check("r1_addr", imem_addr, 32'h40);
        cyc(0, 1, 32'h0000_0513, 0, 0, 32'h40);     // WAIT ack
        check("r2_ins_f", ins_f, 32'h0000_0513);
        cyc(0, 0, 0, 0, 0, 32'h44);                  // ISSUE
        check("r3_proto_err", proto_err, 1);
        cyc(1, 0, 0, 0, 0, 32'h0);
        cyc(0, 0, 0, 0, 0, 32'h0);
        check("r4_proto_err", proto_err, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
